// File: rtl/cordic_pipe_param.sv
// cordic_pipe_param: parametrised, fully pipelined circular CORDIC (rotation/vectoring per sample).
// Define CORDIC_GAIN_COMP_EN to add a registered 1/An gain-compensation stage before saturation.
module cordic_pipe_param #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  output logic             out_mode,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  localparam int XW = WIDTH + 2;
  localparam int PW = 2 * XW;
  localparam logic [127:0] PI_Q = 128'd3454217652359;

  // atan(2^-i) in binary-angle units, from an integer Taylor series in Q40
  function automatic logic [STAGES*WIDTH-1:0] atan_tbl();
    logic [STAGES*WIDTH-1:0] t;
    logic [127:0] a;
    logic [127:0] p;
    logic [127:0] q;
    t = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i == 0) begin
        q = 128'(1) << (WIDTH - 3);
      end else begin
        a = '0;
        p = 128'(1) << (40 - i);
        for (int k = 0; k < 24; k++) begin
          if (k % 2 == 0) a = a + p / 128'(2 * k + 1);
          else            a = a - p / 128'(2 * k + 1);
          p = p >> (2 * i);
        end
        q = ((a << (WIDTH - 1)) + (PI_Q >> 1)) / PI_Q;
      end
      t[i*WIDTH +: WIDTH] = WIDTH'(q);
    end
    return t;
  endfunction

  localparam logic [STAGES*WIDTH-1:0] ATAN = atan_tbl();

  localparam logic signed [XW-1:0] SMAX = XW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [XW-1:0] SMIN = ~SMAX;

  function automatic logic [WIDTH-1:0] sat(logic signed [XW-1:0] v);
    if (v > SMAX) return WIDTH'(SMAX);
    if (v < SMIN) return WIDTH'(SMIN);
    return WIDTH'(v);
  endfunction

  logic signed [XW-1:0] xs [STAGES+1];
  logic signed [XW-1:0] ys [STAGES+1];
  logic [WIDTH-1:0]     zs [STAGES+1];
  logic                 vs [STAGES+1];
  logic                 ms [STAGES+1];

  logic signed [XW-1:0] xe;
  logic signed [XW-1:0] ye;
  logic                 flip;

  assign xe = {{2{x_in[WIDTH-1]}}, x_in};
  assign ye = {{2{y_in[WIDTH-1]}}, y_in};
  // fold the input into the right half-plane by a pi rotation
  assign flip = in_mode ? x_in[WIDTH-1]
                        : (z_in[WIDTH-1] ^ z_in[WIDTH-2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs[0] <= '0;
      ys[0] <= '0;
      zs[0] <= '0;
      vs[0] <= 1'b0;
      ms[0] <= 1'b0;
    end else if (en) begin
      xs[0] <= flip ? -xe : xe;
      ys[0] <= flip ? -ye : ye;
      zs[0] <= {z_in[WIDTH-1] ^ flip, z_in[WIDTH-2:0]};
      vs[0] <= in_valid;
      ms[0] <= in_mode;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_it
    localparam logic [WIDTH-1:0] A = ATAN[i*WIDTH +: WIDTH];
    logic signed [XW-1:0] xsh;
    logic signed [XW-1:0] ysh;
    logic                 dpos;

    assign xsh  = xs[i] >>> i;
    assign ysh  = ys[i] >>> i;
    assign dpos = ms[i] ? ys[i][XW-1] : ~zs[i][WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        xs[i+1] <= '0;
        ys[i+1] <= '0;
        zs[i+1] <= '0;
        vs[i+1] <= 1'b0;
        ms[i+1] <= 1'b0;
      end else if (en) begin
        xs[i+1] <= dpos ? xs[i] - ysh : xs[i] + ysh;
        ys[i+1] <= dpos ? ys[i] + xsh : ys[i] - xsh;
        zs[i+1] <= dpos ? zs[i] - A : zs[i] + A;
        vs[i+1] <= vs[i];
        ms[i+1] <= ms[i];
      end
    end
  end

  logic signed [XW-1:0] xf;
  logic signed [XW-1:0] yf;
  logic [WIDTH-1:0]     zf;
  logic                 vf;
  logic                 mf;

`ifdef CORDIC_GAIN_COMP_EN
  localparam longint KL =
    (64'sd6072529350 * (64'sd1 <<< (WIDTH + 1)) + 64'sd5000000000)
    / 64'sd10000000000;
  localparam logic signed [XW-1:0] KC = XW'(KL);
  localparam logic signed [PW-1:0] RND = PW'(1) <<< WIDTH;

  logic signed [PW-1:0] xp;
  logic signed [PW-1:0] yp;
  logic signed [XW-1:0] xc;
  logic signed [XW-1:0] yc;
  logic [WIDTH-1:0]     zc;
  logic                 vc;
  logic                 mc;

  assign xp = PW'(xs[STAGES]) * PW'(KC) + RND;
  assign yp = PW'(ys[STAGES]) * PW'(KC) + RND;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xc <= '0;
      yc <= '0;
      zc <= '0;
      vc <= 1'b0;
      mc <= 1'b0;
    end else if (en) begin
      xc <= XW'(xp >>> (WIDTH + 1));
      yc <= XW'(yp >>> (WIDTH + 1));
      zc <= zs[STAGES];
      vc <= vs[STAGES];
      mc <= ms[STAGES];
    end
  end

  assign xf = xc;
  assign yf = yc;
  assign zf = zc;
  assign vf = vc;
  assign mf = mc;
`else
  assign xf = xs[STAGES];
  assign yf = ys[STAGES];
  assign zf = zs[STAGES];
  assign vf = vs[STAGES];
  assign mf = ms[STAGES];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (en) begin
      out_valid <= vf;
      if (vf) begin
        out_mode <= mf;
        x_out    <= sat(xf);
        y_out    <= sat(yf);
        z_out    <= zf;
      end
    end
  end

endmodule

// File: tb/tb_cordic_pipe_param.sv
// tb_cordic_pipe_param: scoreboard bench for cordic_pipe_param (WIDTH=16, STAGES=16).
// Directed vectors; expected values are true-magnitude hand values scaled by the build's gain.
module tb_cordic_pipe_param;
  localparam int W = 16;
  localparam int S = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT = S + 3;
  localparam real G   = 1.0;
`else
  localparam int  LAT = S + 2;
  localparam real G   = 1.6467602581;
`endif
  localparam int ZT = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] y_in = '0;
  logic [W-1:0] z_in = '0;
  logic out_valid;
  logic out_mode;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;

  always #5 clk = ~clk;

  cordic_pipe_param #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_mode(out_mode),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  typedef struct {
    logic m;
    int   x;
    int   y;
    int   z;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t last;
  bit   have_last = 0;
  logic [LAT-1:0] vpipe;
  logic en_q;
  int errors = 0;
  int checks = 0;
  int xyt = $rtoi(10.0 * G + 0.5);

  task automatic chk(string n, int act, int exp, int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  function automatic int zdiff(logic [W-1:0] a, int e);
    logic [W-1:0] d;
    d = a - e[W-1:0];
    return $signed(d);
  endfunction

  function automatic int scale(int t);
    real r;
    int  v;
    r = real'(t) * G;
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Expected-timing model: valid bits through LAT enabled registers
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
      en_q  <= 1'b0;
      sb.delete();
    end else begin
      en_q <= en;
      if (en) begin
        vpipe <= {vpipe[LAT-2:0], in_valid};
        if (in_valid) sb.push_back(cur);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        have_last = 0;
      end else begin
        chk("out_valid", int'(out_valid), int'(vpipe[LAT-1]), 0);
        if (en_q && out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0, 0);
          end else begin
            e = sb.pop_front();
            chk("out_mode", int'(out_mode), int'(e.m), 0);
            chk("x_out", int'($signed(x_out)), e.x, xyt);
            chk("y_out", int'($signed(y_out)), e.y, xyt);
            chk("z_out_err", zdiff(z_out, e.z), 0, ZT);
            last = e;
            have_last = 1;
          end
        end else if (!en_q && have_last && out_valid) begin
          chk("x_hold", int'($signed(x_out)), last.x, xyt);
          chk("y_hold", int'($signed(y_out)), last.y, xyt);
        end
      end
    end
  end

  task automatic send(logic m, int x, int y, int z, int ex, int ey, int ez);
    @(negedge clk);
    en = 1'b1;
    in_valid = 1'b1;
    in_mode = m;
    x_in = x[W-1:0];
    y_in = y[W-1:0];
    z_in = z[W-1:0];
    cur = '{m, scale(ex), scale(ey), ez};
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int a;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_out_mode", int'(out_mode), 0, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    chk("rst_y_out", int'(y_out), 0, 0);
    chk("rst_z_out", int'(z_out), 0, 0);
    reset = 1'b0;

    send(0, 16384, 0, 'h2000, 11585, 11585, 0);
    idle(LAT + 2);

    send(0, 16384, 0, 'h6000, -11585, 11585, 0);
    send(0, 16384, 0, 'hA000, -11585, -11585, 0);
    send(1, -12288, -12288, 0, 17378, 0, 'hA000);
    send(0, 32767, 32767, 0, 32767, 32767, 0);
    send(0, -32768, -32768, 0, -32768, -32768, 0);
    idle(LAT + 2);

    for (int k = 0; k < 20; k++) begin
      a = 4000 + 500 * k;
      if (k % 2 == 0) send(0, a, 0, 'h4000, 0, a, 0);
      else            send(1, 0, a, 0, a, 0, 'h4000);
      if (k == 5) idle(1);
      if (k == 17) begin
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    idle(LAT + 3);

    for (int k = 0; k < 5; k++) send(0, 8000, 0, 0, 8000, 0, 0);
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", int'(out_valid), 0, 0);
    chk("rst_mid_x_out", int'(x_out), 0, 0);
    chk("rst_mid_y_out", int'(y_out), 0, 0);
    chk("rst_mid_z_out", int'(z_out), 0, 0);
    chk("rst_mid_out_mode", int'(out_mode), 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(LAT + 3);
    send(1, 0, 9000, 0, 9000, 0, 'h4000);
    idle(LAT + 3);

    chk("drain", sb.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
